ahb_slave_arbiter_gen: RTL
==========================

Name: ahb_slave_arbiter_gen

Overview:
- Per-slave AHB arbiter for the AHB_Gen interconnect; one instance sits in front of each slave port.
- Selects one of MASTER_NUM requesting masters and holds the grant for the full burst, or longer while the master asserts hlock.
- Supersedes the fixed-scheme per-slave arbiters: scheme is a parameter (fixed priority or round-robin), burst length is taken per master, and undefined-length INCR and locked sequences are supported.

Parameters:
- MASTER_NUM, 4, number of masters competing for this slave (2..16).
- ARB_MODE, 1, 0 = fixed priority (index 0 highest); 1 = round-robin.
- ID_W, $clog2(MASTER_NUM), width of hmaster.

Ports:
- hclk  in  1  clock
- hreset_n  in  1  asynchronous active-low reset
- hreq  in  MASTER_NUM  per-master request for this slave
- hlock  in  MASTER_NUM  per-master lock; extends ownership past burst end
- hburst  in  MASTER_NUM x 3  per-master hburst_type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- hready  in  1  slave ready; a beat is accepted when hready=1 and a grant is active
- hgrant  out  MASTER_NUM  registered one-hot grant; all zero when idle
- hsel  out  1  |hgrant
- hmaster  out  ID_W  binary index of the granted master; 0 when idle
- hlast  out  1  combinational pulse on the accepting cycle of the final beat

Behaviour:
- Reset: hgrant=0, hsel=0, hmaster=0, beat counter=0, FSM=IDLE, rr pointer=MASTER_NUM-1 (master 0 wins the first round-robin pick).
- FSM has two states: IDLE and OWNED.
- Arbitration pick:
  - ARB_MODE=0: lowest set index of hreq.
  - ARB_MODE=1: first set hreq index searching from ptr+1 upward, wrapping modulo MASTER_NUM.
  - The rr pointer loads the winner index when a grant is issued.
- IDLE:
  - Pick when any hreq=1; hgrant is one-hot in the next cycle (1-cycle latency) and FSM goes to OWNED.
  - On grant, latch the winner's hburst and clear the counter.
  - Stay in IDLE while hreq=0.
- Burst limit from the latched hburst: SINGLE=1 beat; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16; INCR=undefined.
- Counter: 4 bits; increments on every accepted beat; frozen while hready=0.
- End of ownership (end_evt):
  - Fixed length: accepted beat with count==limit-1. hlast=1 in that cycle.
  - INCR: accepted beat while the owner's hreq=0. hlast=1 in that cycle.
  - If the owner's hlock=1 at end_evt, ownership is kept: hlast still pulses, the counter clears, and the owner's current hburst is relatched. Lock release takes effect at the next end_evt with hlock=0.
- Handover on end_evt without lock:
  - Re-arbitrate in the same cycle, excluding the current owner only when ARB_MODE=1 and another request is pending.
  - The new hgrant appears in the next cycle, with no idle bubble.
  - If no request is pending, go to IDLE with hgrant=0.
- Fixed bursts run to completion regardless of the owner's hreq or hlock changes mid-burst. Requests from other masters never pre-empt.
- hready=0 on the last beat: hlast stays 0 and the grant is held until hready=1.
- Simultaneous requests at end_evt: the pick rule decides. In ARB_MODE=0, index 0 can starve others; this is accepted.
- Reset asserted mid-burst: immediate return to reset values; no partial state survives.
- hburst values are treated as 3-bit unsigned; no other encodings exist.

Test Plan:
- ARB_MODE=1, MASTER_NUM=4, hreq=4'b1111 held, all SINGLE, hready=1 -> grant order m0,m1,m2,m3,m0 on consecutive cycles; hlast=1 every cycle.
- ARB_MODE=0, hreq=4'b1010, m1 INCR4 -> hgrant=4'b0010 for 4 accepted beats; hlast on beat 4; next cycle hgrant=4'b1000 (m1 deasserted) or 4'b0010 again if m1 still requests.
- m2 WRAP8 with hready=0 on beats 3 and 8 -> counter frozen; grant held 10 cycles total; hlast only on the cycle where beat 8 is accepted.
- m0 INCR, hreq held 5 beats then dropped, m3 waiting -> hlast on the accepted cycle with hreq0=0; hgrant=4'b1000, hmaster=3 next cycle.
- m1 hlock=1 across two INCR4 bursts, m0 requesting in ARB_MODE=0 -> m1 keeps the grant for 8 beats; hlast at beats 4 and 8; m0 granted after beat 8.
- hreset_n pulsed low at beat 5 of INCR16 -> hgrant=0, hsel=0, hmaster=0 immediately; after release, m0 wins the first round-robin pick.

Source files
------------

// File: rtl/ahb_slave_arbiter_gen_if.sv
// Request/grant bundle between the AHB_Gen masters and one per-slave arbiter.
// The arbiter uses the slave modport; request drivers use the master modport.
interface ahb_slave_arbiter_gen_if #(
    parameter int MASTER_NUM = 4,
    parameter int ID_W       = $clog2(MASTER_NUM)
);
    logic [MASTER_NUM-1:0]      hreq;
    logic [MASTER_NUM-1:0]      hlock;
    logic [MASTER_NUM-1:0][2:0] hburst;
    logic                       hready;
    logic [MASTER_NUM-1:0]      hgrant;
    logic                       hsel;
    logic [ID_W-1:0]            hmaster;
    logic                       hlast;

    modport master (
        output hreq, hlock, hburst, hready,
        input  hgrant, hsel, hmaster, hlast
    );

    modport slave (
        input  hreq, hlock, hburst, hready,
        output hgrant, hsel, hmaster, hlast
    );
endinterface

// File: rtl/ahb_slave_arbiter_gen.sv
// Per-slave AHB arbiter: fixed-priority or round-robin pick, grant held for a burst or lock.
// Grant registered one cycle after request; hready=0 freezes the beat count and holds the grant.
module ahb_slave_arbiter_gen #(
    parameter int MASTER_NUM = 4,
    parameter int ARB_MODE   = 1,
    parameter int ID_W       = $clog2(MASTER_NUM)
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    ahb_slave_arbiter_gen_if.slave bus
);
    typedef enum logic {IDLE, OWNED} state_t;

    state_t                state, state_nxt;
    logic [MASTER_NUM-1:0] grant, grant_nxt;
    logic [ID_W-1:0]       owner, owner_nxt;
    logic [ID_W-1:0]       ptr, ptr_nxt;
    logic [ID_W-1:0]       pick, idx_w;
    logic [2:0]            burst, burst_nxt;
    logic [3:0]            cnt, cnt_nxt, last_cnt;
    logic                  incr, any_req, accept, end_evt, pick_found;
    int                    base, idx;

    // Round-robin search starts just past the last winner, so the current owner
    // naturally becomes the lowest-priority candidate at handover.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        idx_w      = '0;
        base       = 0;
        if (ARB_MODE == 1) begin
            base = int'(ptr) + 1;
            if (base >= MASTER_NUM) base = 0;
        end
        for (int i = 0; i < MASTER_NUM; i++) begin
            idx = base + i;
            if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
            idx_w = ID_W'(idx);
            if (!pick_found && bus.hreq[idx_w]) begin
                pick       = idx_w;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        incr = (burst == 3'd1);
        case (burst)
            3'd0:       last_cnt = 4'd0;
            3'd2, 3'd3: last_cnt = 4'd3;
            3'd4, 3'd5: last_cnt = 4'd7;
            default:    last_cnt = 4'd15;
        endcase
    end

    assign any_req = |bus.hreq;
    assign accept  = (state == OWNED) && bus.hready;
    assign end_evt = accept && (incr ? !bus.hreq[owner] : (cnt == last_cnt));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        burst_nxt = burst;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OWNED;
                    grant_nxt = {{(MASTER_NUM-1){1'b0}}, 1'b1} << pick;
                    owner_nxt = pick;
                    ptr_nxt   = pick;
                    burst_nxt = bus.hburst[pick];
                    cnt_nxt   = '0;
                end
            end
            OWNED: begin
                if (end_evt) begin
                    cnt_nxt = '0;
                    if (bus.hlock[owner]) begin
                        burst_nxt = bus.hburst[owner];
                    end else if (pick_found) begin
                        grant_nxt = {{(MASTER_NUM-1){1'b0}}, 1'b1} << pick;
                        owner_nxt = pick;
                        ptr_nxt   = pick;
                        burst_nxt = bus.hburst[pick];
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        owner_nxt = '0;
                    end
                end else if (accept) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= ID_W'(MASTER_NUM - 1);
            burst <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            burst <= burst_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.hgrant  = grant;
    assign bus.hsel    = |grant;
    assign bus.hmaster = owner;
    assign bus.hlast   = end_evt;
endmodule
